// File: rtl/avl_mm_read_arbiter.sv
// Two-requester Avalon-MM read arbiter sharing one slave read port.
// Commands and responses pass through combinationally; an in-order tag FIFO routes responses.
module avl_mm_read_arbiter #(
  parameter int unsigned DATA_W          = 256,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ADDR_W-1:0]                  m0_addr,
  input  logic                               m0_read,
  output logic                               m0_waitrequest,
  output logic [DATA_W-1:0]                  m0_readdata,
  output logic                               m0_readdatavalid,
  output logic [1:0]                         m0_response,
  input  logic                               m0_urgent,
  input  logic [ADDR_W-1:0]                  m1_addr,
  input  logic                               m1_read,
  output logic                               m1_waitrequest,
  output logic [DATA_W-1:0]                  m1_readdata,
  output logic                               m1_readdatavalid,
  output logic [1:0]                         m1_response,
  output logic [ADDR_W-1:0]                  s_addr,
  output logic                               s_read,
  input  logic                               s_waitrequest,
  input  logic [DATA_W-1:0]                  s_readdata,
  input  logic                               s_readdatavalid,
  input  logic [1:0]                         s_response,
  input  logic                               clr_err,
  output logic                               spurious_rdv,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

  localparam int unsigned PtrW    = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0]    FifoFull  = CntW'(MAX_OUTSTANDING);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  logic                       grant_lock_q, grant_lock_d;
  logic                       lock_id_q, lock_id_d;
  logic                       last_grant_q, last_grant_d;
  logic [StarveW-1:0]         starve_cnt_q, starve_cnt_d;
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]            count_q, count_d;
  logic                       spurious_q, spurious_d;

  logic gnt;
  logic gnt_read;
  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic pop;
  logic head;

  assign fifo_full  = (count_q == FifoFull);
  assign fifo_empty = (count_q == '0);

  always_comb begin
    gnt = last_grant_q;
    if (grant_lock_q) begin
      gnt = lock_id_q;
    end else if (m0_read && !m1_read) begin
      gnt = 1'b0;
    end else if (!m0_read && m1_read) begin
      gnt = 1'b1;
    end else if (m0_read && m1_read) begin
      if (starve_cnt_q >= StarveMax) begin
        gnt = 1'b1;
      end else if (m0_urgent) begin
        gnt = 1'b0;
      end else begin
        gnt = !last_grant_q;
      end
    end
  end

  assign gnt_read = gnt ? m1_read : m0_read;
  assign s_read   = gnt_read && !fifo_full;
  assign s_addr   = gnt ? m1_addr : m0_addr;
  assign accept   = s_read && !s_waitrequest;

  // A port that is not requesting never sees a released stall.
  assign m0_waitrequest = !(!gnt && m0_read && !fifo_full && !s_waitrequest);
  assign m1_waitrequest = !(gnt && m1_read && !fifo_full && !s_waitrequest);

  assign pop  = s_readdatavalid && !fifo_empty;
  assign head = tag_q[rd_ptr_q];

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_response      = s_response;
  assign m1_response      = s_response;
  assign m0_readdatavalid = pop && !head;
  assign m1_readdatavalid = pop && head;
  assign spurious_rdv     = spurious_q;
  assign outstanding      = count_q;

  always_comb begin
    grant_lock_d = grant_lock_q;
    lock_id_d    = lock_id_q;
    last_grant_d = last_grant_q;
    starve_cnt_d = starve_cnt_q;
    tag_d        = tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    spurious_d   = spurious_q;

    if (accept) begin
      grant_lock_d    = 1'b0;
      last_grant_d    = gnt;
      tag_d[wr_ptr_q] = gnt;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end else if (s_read) begin
      // Slave stalled: hold owner and address until the command is taken.
      grant_lock_d = 1'b1;
      lock_id_d    = gnt;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    if (accept && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!accept && pop) begin
      count_d = count_q - CntW'(1);
    end

    if (!m1_read || (accept && gnt)) begin
      starve_cnt_d = '0;
    end else if (accept && !gnt && m0_read && (starve_cnt_q != StarveMax)) begin
      starve_cnt_d = starve_cnt_q + StarveW'(1);
    end

    if (s_readdatavalid && fifo_empty) begin
      spurious_d = 1'b1;
    end else if (clr_err) begin
      spurious_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_lock_q <= 1'b0;
      lock_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
      starve_cnt_q <= '0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      spurious_q   <= 1'b0;
    end else begin
      grant_lock_q <= grant_lock_d;
      lock_id_q    <= lock_id_d;
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      spurious_q   <= spurious_d;
    end
  end

endmodule

// File: tb/tb_avl_mm_read_arbiter.sv
// Self-checking bench for avl_mm_read_arbiter: cycle vector table, arbitration
// pattern scoreboard, and a reset-mid-transfer sequence.
module tb_avl_mm_read_arbiter;
  localparam int DW = 256;
  localparam int AW = 32;
  localparam int MO = 4;
  localparam int SL = 8;
  localparam logic [AW-1:0] A0 = 32'h0000_1000;
  localparam logic [AW-1:0] A1 = 32'h0000_2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] m0_addr = A0, m1_addr = A1;
  logic          m0_read = 0, m1_read = 0, m0_urgent = 0;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [1:0]    m0_response, m1_response;
  logic [AW-1:0] s_addr;
  logic          s_read;
  logic          s_waitrequest = 0;
  logic [DW-1:0] s_readdata = '0;
  logic          s_readdatavalid = 0;
  logic [1:0]    s_response = 0;
  logic          clr_err = 0;
  logic          spurious_rdv;
  logic [$clog2(MO):0] outstanding;

  avl_mm_read_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m0_response(m0_response), .m0_urgent(m0_urgent),
    .m1_addr(m1_addr), .m1_read(m1_read), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .m1_response(m1_response),
    .s_addr(s_addr), .s_read(s_read), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid), .s_response(s_response),
    .clr_err(clr_err), .spurious_rdv(spurious_rdv), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r0, r1, urg, sw, rdv;
    logic [1:0] resp;
    logic clr;
    logic e_sread, e_a1, e_w0, e_w1, e_v0, e_v1;
    int   e_out;
    logic e_spur;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } rsp_t;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t vt[$];
  bit   acc_q[$];
  rsp_t rsp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mv(input logic r0, r1, urg, sw, rdv, input logic [1:0] resp,
                              input logic clr, es, ea1, w0, w1, v0, v1,
                              input int eo, input logic sp);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.urg = urg; v.sw = sw; v.rdv = rdv; v.resp = resp; v.clr = clr;
    v.e_sread = es; v.e_a1 = ea1; v.e_w0 = w0; v.e_w1 = w1; v.e_v0 = v0; v.e_v1 = v1;
    v.e_out = eo; v.e_spur = sp;
    return v;
  endfunction

  task automatic idle_inputs();
    m0_read = 0; m1_read = 0; m0_urgent = 0; s_waitrequest = 0;
    s_readdatavalid = 0; s_response = 0; clr_err = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    check("rst_outstanding", 64'(outstanding), 0);
    check("rst_spurious", 64'(spurious_rdv), 0);
    check("rst_s_read", 64'(s_read), 0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // Drives both ports continuously; a one-cycle-latency slave answers each accept.
  task automatic burst(input logic urg, input int n);
    bit          pend = 0;
    logic [31:0] pdata = 0;
    int          seq = 0;
    rsp_t        r;
    logic        port;
    for (int c = 0; c <= n; c++) begin
      @(posedge clk); #1;
      m0_read = (c < n); m1_read = (c < n); m0_urgent = urg; s_waitrequest = 0;
      s_readdatavalid = pend; s_readdata = {224'b0, pdata}; s_response = 0;
      pend = 0;
      @(negedge clk);
      if (m0_readdatavalid || m1_readdatavalid) begin
        if (rsp_q.size() == 0) begin
          check("sb_unexpected_rdv", 1, 0);
        end else begin
          r = rsp_q.pop_front();
          check("sb_rdv_m0", 64'(m0_readdatavalid), 64'(!r.port));
          check("sb_rdv_m1", 64'(m1_readdatavalid), 64'(r.port));
          check("sb_rdata", r.port ? m1_readdata[63:0] : m0_readdata[63:0], 64'(r.data));
        end
      end
      if (s_read && !s_waitrequest) begin
        port = (s_addr == A1);
        if (acc_q.size() == 0) check("sb_extra_accept", 1, 0);
        else check("sb_accept_port", 64'(port), 64'(acc_q.pop_front()));
        r.port = port; r.data = 32'hC000 + seq;
        rsp_q.push_back(r);
        pend = 1; pdata = r.data; seq++;
      end
    end
    check("sb_accepts_left", 64'(acc_q.size()), 0);
    check("sb_rsp_left", 64'(rsp_q.size()), 0);
    acc_q.delete();
    rsp_q.delete();
  endtask

  initial begin
    // r0 r1 urg sw rdv resp clr | s_read addr1 w0 w1 v0 v1 outstanding spurious
    vt.push_back(mv(0,0,0,0,0,2'd0,0, 0,0,1,1,0,0, 0,0)); // idle after reset
    vt.push_back(mv(1,0,0,0,0,2'd0,0, 1,0,0,1,0,0, 0,0)); // m0 reads 0x1000
    vt.push_back(mv(0,0,0,0,1,2'd0,0, 0,0,1,1,1,0, 1,0)); // its response
    vt.push_back(mv(0,0,0,0,0,2'd0,0, 0,0,1,1,0,0, 0,0));
    vt.push_back(mv(0,1,0,1,0,2'd0,0, 1,1,1,1,0,0, 0,0)); // m1 stalled by slave
    vt.push_back(mv(1,1,1,1,0,2'd0,0, 1,1,1,1,0,0, 0,0)); // urgent m0 cannot steal
    vt.push_back(mv(1,1,1,1,0,2'd0,0, 1,1,1,1,0,0, 0,0));
    vt.push_back(mv(1,1,1,0,0,2'd0,0, 1,1,1,0,0,0, 0,0)); // m1 accepted first
    vt.push_back(mv(1,0,1,0,1,2'd2,0, 1,0,0,1,0,1, 1,0)); // m1 error response
    vt.push_back(mv(0,0,0,0,1,2'd0,0, 0,0,1,1,1,0, 1,0));
    vt.push_back(mv(1,0,0,0,0,2'd0,0, 1,0,0,1,0,0, 0,0)); // fill FIFO
    vt.push_back(mv(0,1,0,0,0,2'd0,0, 1,1,1,0,0,0, 1,0));
    vt.push_back(mv(1,0,0,0,0,2'd0,0, 1,0,0,1,0,0, 2,0));
    vt.push_back(mv(0,1,0,0,0,2'd0,0, 1,1,1,0,0,0, 3,0));
    vt.push_back(mv(1,1,0,0,0,2'd0,0, 0,0,1,1,0,0, 4,0)); // full: blocked
    vt.push_back(mv(1,1,0,0,1,2'd0,0, 0,0,1,1,1,0, 4,0)); // pop, still registered full
    vt.push_back(mv(1,1,0,0,0,2'd0,0, 1,0,0,1,0,0, 3,0));
    vt.push_back(mv(1,1,0,0,1,2'd1,0, 0,0,1,1,0,1, 4,0));
    vt.push_back(mv(0,0,0,0,1,2'd0,0, 0,0,1,1,1,0, 3,0)); // drain
    vt.push_back(mv(0,0,0,0,1,2'd0,0, 0,0,1,1,0,1, 2,0));
    vt.push_back(mv(0,0,0,0,1,2'd0,0, 0,0,1,1,1,0, 1,0));
    vt.push_back(mv(0,0,0,0,1,2'd3,0, 0,0,1,1,0,0, 0,0)); // spurious response
    vt.push_back(mv(0,0,0,0,0,2'd0,1, 0,0,1,1,0,0, 0,1)); // flag set, clear it
    vt.push_back(mv(0,0,0,0,0,2'd0,0, 0,0,1,1,0,0, 0,0));
    vt.push_back(mv(0,0,0,0,1,2'd0,1, 0,0,1,1,0,0, 0,0)); // set beats clear
    vt.push_back(mv(0,0,0,0,0,2'd0,1, 0,0,1,1,0,0, 0,1));
    vt.push_back(mv(0,0,0,0,0,2'd0,0, 0,0,1,1,0,0, 0,0));

    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      m0_read = vt[i].r0; m1_read = vt[i].r1; m0_urgent = vt[i].urg;
      s_waitrequest = vt[i].sw; s_readdatavalid = vt[i].rdv; s_response = vt[i].resp;
      clr_err = vt[i].clr; s_readdata = {224'b0, 32'hA000 + 32'(i)};
      @(negedge clk);
      check($sformatf("v%0d_s_read", i), 64'(s_read), 64'(vt[i].e_sread));
      if (vt[i].e_sread) check($sformatf("v%0d_s_addr", i), 64'(s_addr), 64'(vt[i].e_a1 ? A1 : A0));
      check($sformatf("v%0d_m0_wait", i), 64'(m0_waitrequest), 64'(vt[i].e_w0));
      check($sformatf("v%0d_m1_wait", i), 64'(m1_waitrequest), 64'(vt[i].e_w1));
      check($sformatf("v%0d_m0_rdv", i), 64'(m0_readdatavalid), 64'(vt[i].e_v0));
      check($sformatf("v%0d_m1_rdv", i), 64'(m1_readdatavalid), 64'(vt[i].e_v1));
      check($sformatf("v%0d_outstanding", i), 64'(outstanding), 64'(vt[i].e_out));
      check($sformatf("v%0d_spurious", i), 64'(spurious_rdv), 64'(vt[i].e_spur));
      if (vt[i].e_v0) begin
        check($sformatf("v%0d_m0_resp", i), 64'(m0_response), 64'(vt[i].resp));
        check($sformatf("v%0d_m0_data", i), m0_readdata[63:0], 64'(32'hA000 + 32'(i)));
      end
      if (vt[i].e_v1) begin
        check($sformatf("v%0d_m1_resp", i), 64'(m1_response), 64'(vt[i].resp));
        check($sformatf("v%0d_m1_data", i), m1_readdata[63:0], 64'(32'hA000 + 32'(i)));
      end
    end

    // Round robin: ties alternate starting with port 0.
    do_reset();
    for (int k = 0; k < 8; k++) acc_q.push_back(k[0]);
    burst(1'b0, 8);

    // Urgent port 0 wins SL times in a row, then port 1 is forced through.
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < SL; k++) acc_q.push_back(1'b0);
      acc_q.push_back(1'b1);
    end
    burst(1'b1, 2 * (SL + 1));

    // Reset with a read in flight: the late response is flagged, not routed.
    do_reset();
    @(posedge clk); #1;
    m0_read = 1;
    @(negedge clk);
    check("mid_accept", 64'(s_read && !m0_waitrequest), 1);
    @(posedge clk); #1;
    m0_read = 0;
    @(negedge clk);
    check("mid_outstanding", 64'(outstanding), 1);
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    check("mid_flushed", 64'(outstanding), 0);
    @(posedge clk); #1;
    rst_n = 1;
    s_readdatavalid = 1;
    @(negedge clk);
    check("mid_no_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 0);
    @(posedge clk); #1;
    s_readdatavalid = 0;
    @(negedge clk);
    check("mid_spurious", 64'(spurious_rdv), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/avl_mm_read_arbiter.md
# avl_mm_read_arbiter

Two-requester Avalon-MM read arbiter that shares one 256-bit memory read port between the pixel uploader (port 0) and a second read master (port 1, e.g. command/LUT fetch). It picks a winner per command, holds the grant while the slave stalls, and routes each read response back to its issuer through an in-order tag FIFO. It adds zero cycles of latency on both command and response paths, so a requester relying on fixed slave read latency sees that latency unchanged.

## Interface
- DATA_W, 256, read data width
- ADDR_W, 32, address width
- MAX_OUTSTANDING, 4, tag FIFO depth (power of 2, ≥2)
- STARVE_LIMIT, 8, consecutive losses of port 1 before it is forced to win
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m0_addr / m1_addr  in  ADDR_W  requester addresses
- m0_read / m1_read  in  1  requester read strobes
- m0_waitrequest / m1_waitrequest  out  1  per-requester stall
- m0_readdata / m1_readdata  out  DATA_W  response data (broadcast of s_readdata)
- m0_readdatavalid / m1_readdatavalid  out  1  response valid, owner only
- m0_response / m1_response  out  2  response code (broadcast of s_response)
- m0_urgent  in  1  port 0 priority request (pixel FIFO below threshold)
- s_addr  out  ADDR_W  slave address
- s_read  out  1  slave read strobe
- s_waitrequest  in  1  slave stall
- s_readdata  in  DATA_W;  s_readdatavalid  in  1;  s_response  in  2
- clr_err  in  1  clears spurious_rdv
- spurious_rdv  out  1  sticky: readdatavalid with no outstanding read
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  tag FIFO occupancy

## Operation
- Registered state: grant_lock, lock_id, last_grant, starve_cnt, tag FIFO (1-bit entries, wr/rd pointers, count), spurious_rdv.
- Grant (combinational, id g):
  - grant_lock=1 → g=lock_id.
  - else only one mX_read → that port.
  - else both: starve_cnt ≥ STARVE_LIMIT → 1; else m0_urgent → 0; else g = !last_grant (round-robin).
  - else neither → g=last_grant, s_read=0.
- s_read = mg_read & !fifo_full; s_addr = mg_addr.
- mX_waitrequest = !(g==X & !fifo_full & !s_waitrequest). Non-granted or non-requesting port always sees waitrequest=1.
- Accept = s_read & !s_waitrequest: push g into tag FIFO, last_grant<=g, grant_lock<=0.
- s_read & s_waitrequest: grant_lock<=1, lock_id<=g; address and owner stay fixed until accept.
- starve_cnt: +1 (saturating) when both request, m1 loses and port 0 is accepted; cleared on port-1 accept or m1_read=0.
- Response: on s_readdatavalid with FIFO non-empty, pop head h; mh_readdatavalid=1 same cycle; other port 0.
- s_readdatavalid with FIFO empty: no mX_readdatavalid; spurious_rdv<=1; data dropped.
- Push and pop in the same cycle: count unchanged, both pointers advance; legal when full (pop frees the slot next cycle only; s_read uses registered full).
- spurious_rdv cleared by clr_err; set wins if both same cycle.

## Timing
- Reset values: grant_lock=0, lock_id=0, last_grant=1 (port 0 wins first tie), starve_cnt=0, FIFO empty, outstanding=0, spurious_rdv=0; s_read=0 and mX_readdatavalid=0 while requesters idle.
- Command path: 0 cycles (mX → s_ combinational). Response path: 0 cycles.
- Back-to-back accepts allowed every cycle while FIFO not full.
- Reset mid-transfer: FIFO flushed; responses arriving after reset release flag spurious_rdv.
- Slave must return responses in order; response error codes are forwarded, not interpreted.

## Test plan
- m0 reads 0x1000 only, slave accepts immediately, rdv next cycle → s_addr=0x1000, m0_readdatavalid=1 one cycle later, m1_readdatavalid=0, outstanding 0→1→0.
- Both read continuously, m0_urgent=0 → accepts alternate 0,1,0,1 starting with 0; responses routed in same order.
- m0_urgent=1, both read continuously, STARVE_LIMIT=8 → 8 port-0 accepts, then one port-1 accept, pattern repeats.
- s_waitrequest high 3 cycles on m1 command while m0 starts reading with urgent → s_addr stays m1_addr all 3 cycles, m1 accepted first, m0_waitrequest=1 throughout.
- Slave delays rdv; 4 accepts fill FIFO → s_read=0, both waitrequests=1 until first rdv pops; outstanding reaches 4, never 5.
- rdv with outstanding=0 → spurious_rdv=1, no mX_readdatavalid; clr_err pulse → 0. rdv with s_response=2'b10 for port-1 read → m1_response=2'b10, m1_readdatavalid=1.
